// File: rtl/apb_regfile_slave.sv
// APB3 completer exposing ID, scratch, W1C status, cycle counter and control registers.
// A setup cycle is recognised from the bus while idle; the registered state tracks the access phase.
module apb_regfile_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0123_4560,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hB0B0_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic [7:0]  status_in,
  output logic [31:0] ctrl_out,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0] scratch_q, scratch_d, ctrl_q, ctrl_d, counter_q;
  logic [7:0]  status_q, status_d, w1c_mask;
  logic        irq_q;

  logic        setup, capture, load_rsp, commit, dec_hit, dec_err, dec_write;
  logic [31:0] dec_addr;

  assign setup = psel & ~penable;

  // With zero wait states the response is decoded straight from the setup-phase bus.
  assign dec_addr  = capture ? paddr : addr_q;
  assign dec_write = capture ? pwrite : write_q;
  assign dec_hit   = (dec_addr[31:5] == BASE_ADDR[31:5]) && (dec_addr[1:0] == 2'b00) &&
                     (dec_addr[4:0] <= 5'h10);
  assign dec_err   = !dec_hit ||
                     (dec_write && (dec_addr[4:0] == 5'h00 || dec_addr[4:0] == 5'h0C));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      addr_q     <= 32'd0;
      write_q    <= 1'b0;
      wdata_q    <= 32'd0;
      prdata_q   <= 32'd0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      scratch_q  <= 32'd0;
      ctrl_q     <= 32'd0;
      status_q   <= 8'd0;
      counter_q  <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      counter_q  <= counter_q + 32'd1;
      irq_q      <= |(status_q & ctrl_q[15:8]);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    capture    = 1'b0;
    load_rsp   = 1'b0;
    unique case (state_q)
      StIdle, StReady: begin
        state_d = StIdle;
        if (setup) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d  = StReady;
            load_rsp = 1'b1;
          end else begin
            state_d    = StWait;
            wait_cnt_d = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (wait_cnt_q == 4'd0) begin
          state_d  = StReady;
          load_rsp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (capture) begin
      addr_d  = paddr;
      write_d = pwrite;
      wdata_d = pwdata;
    end
  end

  always_comb begin
    pready_d  = load_rsp;
    pslverr_d = 1'b0;
    prdata_d  = 32'd0;
    if (load_rsp) begin
      if (dec_err) begin
        pslverr_d = 1'b1;
      end else begin
        unique case (dec_addr[4:2])
          3'd0:    prdata_d = ID_VALUE;
          3'd1:    prdata_d = scratch_q;
          3'd2:    prdata_d = {24'd0, status_q};
          3'd3:    prdata_d = counter_q;
          3'd4:    prdata_d = ctrl_q;
          default: prdata_d = 32'd0;
        endcase
      end
    end

    commit    = (state_q == StReady) && psel && penable && write_q && !pslverr_q;
    scratch_d = (commit && addr_q[4:2] == 3'd1) ? wdata_q : scratch_q;
    ctrl_d    = (commit && addr_q[4:2] == 3'd4) ? wdata_q : ctrl_q;
    w1c_mask  = (commit && addr_q[4:2] == 3'd2) ? wdata_q[7:0] : 8'd0;
    // New events win over a same-cycle clear.
    status_d  = (status_q & ~w1c_mask) | status_in;
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign ctrl_out = ctrl_q;
  assign irq      = irq_q;

endmodule
